// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_if
// Description : Bundles the core-side request/response handshake and the
//               byte-lane RAM port of the load/store unit.
//               master : the core plus RAM side (drives requests, read data)
//               slave  : the LSU (drives ready, response and RAM controls)
// Signals     : req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/
//               req_wdata, resp_valid/resp_rdata/resp_err,
//               ram_wen/ram_w_addr/ram_w_data/ram_ren/ram_r_addr/ram_r_data
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_lsu_if #(
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  logic [3:0]    ram_wen;
  logic [DW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_ren;
  logic [DW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr,
    output ram_r_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr,
    input  ram_r_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Load/store unit between the execute stage and a 4-lane
//               byte-enabled data RAM. Stores turn into per-lane write
//               enables with lane-replicated data in the accept cycle. Loads
//               issue one RAM read, then extract/extend the returned word
//               into a registered response two cycles after accept.
//               Build option LSU_MISALIGN_TRAP_EN: misaligned accesses are
//               reported as errors instead of being force-aligned.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - mem_lsu_if.slave (request, response, RAM port)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu #(
  parameter int MEM_BYTES = 16384,
  parameter int DW        = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  mem_lsu_if.slave  bus
);

  localparam logic [DW-1:0] c_mem_limit = DW'(MEM_BYTES);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LD_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [DW-1:0] r_resp_rdata;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_unsigned;

  logic          w_accept;
  logic          w_err;
  logic [DW-1:0] w_addr_al;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_load_data;

  assign bus.req_ready  = (r_state == ST_IDLE) & rst;
  assign w_accept       = bus.req_valid & bus.req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment is trapped, so any access that reaches the RAM is aligned.
  assign w_err = (bus.req_size == 2'd3)
               | ((bus.req_size == 2'd1) & bus.req_addr[0])
               | ((bus.req_size == 2'd2) & (bus.req_addr[1:0] != 2'b00))
               | (bus.req_addr >= c_mem_limit);
  assign w_addr_al = bus.req_addr;
`else
  // Misaligned halves/words are silently aligned down to their natural
  // boundary; only reserved size and out-of-range are errors.
  assign w_err = (bus.req_size == 2'd3) | (bus.req_addr >= c_mem_limit);
  always_comb begin
    w_addr_al = bus.req_addr;
    if (bus.req_size == 2'd1)
      w_addr_al[0] = 1'b0;
    else if (bus.req_size == 2'd2)
      w_addr_al[1:0] = 2'b00;
  end
`endif

  // RAM controls are driven only in the cycle a clean request is accepted.
  always_comb begin
    bus.ram_wen    = 4'b0000;
    bus.ram_w_addr = '0;
    bus.ram_w_data = '0;
    bus.ram_ren    = 1'b0;
    bus.ram_r_addr = '0;
    if (w_accept && !w_err) begin
      if (bus.req_we) begin
        bus.ram_w_addr = w_addr_al;
        case (bus.req_size)
          2'd0: begin
            bus.ram_wen    = 4'b0001 << w_addr_al[1:0];
            bus.ram_w_data = {4{bus.req_wdata[7:0]}};
          end
          2'd1: begin
            bus.ram_wen    = w_addr_al[1] ? 4'b1100 : 4'b0011;
            bus.ram_w_data = {2{bus.req_wdata[15:0]}};
          end
          default: begin
            bus.ram_wen    = 4'b1111;
            bus.ram_w_data = bus.req_wdata;
          end
        endcase
      end else begin
        bus.ram_ren    = 1'b1;
        bus.ram_r_addr = w_addr_al;
      end
    end
  end

  // Lane extraction uses the offset latched at accept time.
  always_comb begin
    w_byte = 8'h00;
    case (r_off)
      2'd0:    w_byte = bus.ram_r_data[7:0];
      2'd1:    w_byte = bus.ram_r_data[15:8];
      2'd2:    w_byte = bus.ram_r_data[23:16];
      default: w_byte = bus.ram_r_data[31:24];
    endcase
    w_half = r_off[1] ? bus.ram_r_data[31:16] : bus.ram_r_data[15:0];
  end

  always_comb begin
    w_load_data = bus.ram_r_data;
    if (r_size == 2'd0)
      w_load_data = r_unsigned ? {24'h000000, w_byte}
                               : {{24{w_byte[7]}}, w_byte};
    else if (r_size == 2'd1)
      w_load_data = r_unsigned ? {16'h0000, w_half}
                               : {{16{w_half[15]}}, w_half};
  end

  // Response registers default to idle every cycle so resp_valid is a
  // single-cycle pulse; reset during LD_WAIT simply drops the load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (bus.req_we || w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_err;
            end else begin
              r_off      <= w_addr_al[1:0];
              r_size     <= bus.req_size;
              r_unsigned <= bus.req_unsigned;
              r_state    <= ST_LD_WAIT;
            end
          end
        end
        default: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Directed self-checking bench for mem_lsu. Acts as the core
//               and as a 4096 x 32 byte-enabled RAM with one-cycle reads.
//               Inputs change on the falling edge; outputs are checked
//               1 time unit after the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_lsu_if #(.DW(32)) bus ();

  mem_lsu #(.MEM_BYTES(16384), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural data RAM
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (bus.ram_wen[l])
        mem[bus.ram_w_addr[13:2]][8*l +: 8] <= bus.ram_w_data[8*l +: 8];
    if (bus.ram_ren)
      bus.ram_r_data <= mem[bus.ram_r_addr[13:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    #1;
  endtask

  // Store: lanes checked in the accept cycle, response the next cycle.
  task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_wen,
                          input logic [31:0] exp_wdata, input logic exp_err);
    drive(1'b1, size, 1'b0, addr, wdata);
    check({tag, "_wen"},   {28'h0, bus.ram_wen}, {28'h0, exp_wen});
    check({tag, "_wdata"}, bus.ram_w_data, exp_wdata);
    check({tag, "_ren"},   {31'h0, bus.ram_ren}, 32'h0);
    idle();
    check({tag, "_rvalid"}, {31'h0, bus.resp_valid}, 32'h1);
    check({tag, "_rerr"},   {31'h0, bus.resp_err}, {31'h0, exp_err});
  endtask

  // Clean load: ren at accept, no response at T+1, response at T+2.
  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp_raddr,
                         input logic [31:0] exp_data);
    drive(1'b0, size, uns, addr, 32'h0);
    check({tag, "_ren"},   {31'h0, bus.ram_ren}, 32'h1);
    check({tag, "_raddr"}, bus.ram_r_addr, exp_raddr);
    idle();
    check({tag, "_busy"},  {31'h0, bus.req_ready}, 32'h0);
    check({tag, "_early"}, {31'h0, bus.resp_valid}, 32'h0);
    idle();
    check({tag, "_rvalid"}, {31'h0, bus.resp_valid}, 32'h1);
    check({tag, "_rerr"},   {31'h0, bus.resp_err}, 32'h0);
    check({tag, "_rdata"},  bus.resp_rdata, exp_data);
  endtask

  // Erroring load: no RAM access, error response at T+1.
  task automatic do_err_load(input string tag, input logic [1:0] size, input logic [31:0] addr);
    drive(1'b0, size, 1'b0, addr, 32'h0);
    check({tag, "_ren"}, {31'h0, bus.ram_ren}, 32'h0);
    check({tag, "_wen"}, {28'h0, bus.ram_wen}, 32'h0);
    idle();
    check({tag, "_rvalid"}, {31'h0, bus.resp_valid}, 32'h1);
    check({tag, "_rerr"},   {31'h0, bus.resp_err}, 32'h1);
    check({tag, "_rdata"},  bus.resp_rdata, 32'h0);
  endtask

  initial begin
    bus.req_valid    = 1'b1;  // held high in reset: must not be accepted
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'h0;
    bus.ram_r_data   = 32'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",  {31'h0, bus.req_ready}, 32'h0);
    check("rst_ren",    {31'h0, bus.ram_ren}, 32'h0);
    check("rst_rvalid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_rerr",   {31'h0, bus.resp_err}, 32'h0);
    check("rst_rdata",  bus.resp_rdata, 32'h0);
    idle();
    rst = 1'b1;
    #1;
    check("post_rst_ready", {31'h0, bus.req_ready}, 32'h1);

    // 1. word store then word load
    do_store("st_w", 2'd2, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0);
    check("st_w_waddr_dbg", mem[4], 32'hDEADBEEF);
    do_load("ld_w", 2'd2, 1'b0, 32'h10, 32'h10, 32'hDEADBEEF);

    // 2. byte store into lane 3, signed and unsigned byte loads
    do_store("st_b", 2'd0, 32'h13, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 1'b0);
    do_load("ld_bs", 2'd0, 1'b0, 32'h13, 32'h13, 32'hFFFFFFA5);
    do_load("ld_bu", 2'd0, 1'b1, 32'h13, 32'h13, 32'h000000A5);
    do_load("ld_w2", 2'd2, 1'b0, 32'h10, 32'h10, 32'hA5ADBEEF);

    // 3. half loads of 0x8001_7FFF
    do_store("st_w3", 2'd2, 32'h10, 32'h80017FFF, 4'b1111, 32'h80017FFF, 1'b0);
    do_load("ld_hs_hi", 2'd1, 1'b0, 32'h12, 32'h12, 32'hFFFF8001);
    do_load("ld_hs_lo", 2'd1, 1'b0, 32'h10, 32'h10, 32'h00007FFF);
    do_load("ld_hu_hi", 2'd1, 1'b1, 32'h12, 32'h12, 32'h00008001);

    // Half store into upper lanes
    do_store("st_h", 2'd1, 32'h12, 32'h00001234, 4'b1100, 32'h12341234, 1'b0);
    do_load("ld_w4", 2'd2, 1'b0, 32'h10, 32'h10, 32'h12347FFF);

    // 4. misaligned half load @0x11
`ifdef LSU_MISALIGN_TRAP_EN
    do_err_load("ld_h_mis", 2'd1, 32'h11);
    do_err_load("ld_w_mis", 2'd2, 32'h12);
`else
    do_load("ld_h_mis", 2'd1, 1'b0, 32'h11, 32'h10, 32'h00007FFF);
    do_load("ld_w_mis", 2'd2, 1'b0, 32'h13, 32'h10, 32'h12347FFF);
`endif

    // 5. out-of-range load, last in-range word, reserved-size store
    do_err_load("ld_oor", 2'd2, 32'h00004000);
    do_err_load("ld_rsv", 2'd3, 32'h10);
    do_store("st_rsv", 2'd3, 32'h20, 32'hCAFEF00D, 4'b0000, 32'h0, 1'b1);
    do_store("st_last", 2'd2, 32'h00003FFC, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 1'b0);
    do_load("ld_last", 2'd2, 1'b0, 32'h00003FFC, 32'h00003FFC, 32'h0BADF00D);

    // Back-to-back byte stores on four consecutive cycles
    for (int i = 0; i < 4; i++) begin
      logic [7:0]  v;
      logic [3:0]  w;
      v = 8'h11 * 8'(i + 1);
      w = 4'b0001 << i;
      drive(1'b1, 2'd0, 1'b0, 32'h20 + 32'(i), {24'h0, v});
      check("b2b_ready", {31'h0, bus.req_ready}, 32'h1);
      check("b2b_wen",   {28'h0, bus.ram_wen}, {28'h0, w});
      check("b2b_wdata", bus.ram_w_data, {4{v}});
      if (i > 0) check("b2b_rvalid", {31'h0, bus.resp_valid}, 32'h1);
    end
    idle();
    check("b2b_rvalid_last", {31'h0, bus.resp_valid}, 32'h1);
    idle();
    check("b2b_rvalid_end", {31'h0, bus.resp_valid}, 32'h0);
    do_load("ld_b2b", 2'd2, 1'b0, 32'h20, 32'h20, 32'h44332211);

    // 6. reset asserted while in LD_WAIT
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("abort_ren", {31'h0, bus.ram_ren}, 32'h1);
    idle();
    rst = 1'b0;
    #1;
    check("abort_ready",  {31'h0, bus.req_ready}, 32'h0);
    check("abort_rvalid", {31'h0, bus.resp_valid}, 32'h0);
    idle();
    check("abort_rvalid2", {31'h0, bus.resp_valid}, 32'h0);
    check("abort_rdata",   bus.resp_rdata, 32'h0);
    rst = 1'b1;
    idle();
    check("abort_rvalid3", {31'h0, bus.resp_valid}, 32'h0);
    check("abort_ready2",  {31'h0, bus.req_ready}, 32'h1);
    do_load("ld_after", 2'd2, 1'b0, 32'h20, 32'h20, 32'h44332211);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
